dsp_add_checker: RTL and testbench

Synthesizable streaming scoreboard for the Ultrascale DSP primitives: the receiving, checking end of a `dsp_add` stimulus stream. It observes the operands handed to a pipelined `dsp_add` instance and computes the reference sum. It delays that sum by the DUT's pipeline latency, compares it against the DUT output, and accumulates pass/fail counts over a fixed-length run. It sits beside the DUT in on-board or simulation harnesses, so primitive checks run without a behavioural testbench.

---
 rtl/dsp_add_checker.sv | 196 +++++++++++++++++++
 tb/tb_dsp_add_checker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_add_checker.sv
// dsp_add_checker: receiving end of a dsp_add stimulus stream. Rebuilds the
// reference sum from the operands handed to the DUT, delays it by the DUT
// pipeline depth and scores the DUT result over a fixed-length run.
//
// Optional feature macro: DSP_CHECKER_FIRST_FAIL_EN
//   defined   -> capture index/expected/actual of the first mismatch of a run
//   undefined -> first_fail_* outputs tied to zero, no capture registers
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start; in_valid ignored
// ST_RUN   | issuing vectors on in_valid, comparing delayed entries
// ST_DRAIN | all vectors issued, flushing the delay line
// ST_DONE  | run finished, counters frozen until the next start
module dsp_add_checker #(
  parameter int width     = 8,
  parameter int latency   = 2,
  parameter int num_tests = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [width-1:0] y,
  output logic [31:0]      pass_count,
  output logic [31:0]      fail_count,
  output logic             mismatch,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      first_fail_index,
  output logic [width-1:0] first_fail_exp,
  output logic [width-1:0] first_fail_act
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(num_tests - 1);

  state_t           state;
  logic [15:0]      issue_idx;
  logic [width-1:0] sum_ab;
  logic             issue_fire;
  logic             issue_last;
  logic             cmp_valid;
  logic [width-1:0] cmp_exp;
  logic [15:0]      cmp_idx;
  logic             cmp_ok;
  logic             cmp_last;

  // Carry out of the sum is dropped: the DUT result is only width bits wide.
  assign sum_ab     = a + b;
  assign issue_fire = (state == ST_RUN) && in_valid;
  assign issue_last = issue_fire && (issue_idx == LAST_IDX);

  generate
    if (latency == 0) begin : g_direct
      // Zero-depth DUT: score the same-cycle operands and result directly.
      assign cmp_valid = issue_fire;
      assign cmp_exp   = sum_ab;
      assign cmp_idx   = issue_idx;
    end else begin : g_delay
      logic             dl_valid [latency];
      logic [width-1:0] dl_exp   [latency];
      logic [15:0]      dl_idx   [latency];

      // Delay line: one entry per edge, bubbles carry valid=0.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < latency; i++) begin
            dl_valid[i] <= 1'b0;
            dl_exp[i]   <= '0;
            dl_idx[i]   <= '0;
          end
        end else begin
          dl_valid[0] <= issue_fire;
          dl_exp[0]   <= sum_ab;
          dl_idx[0]   <= issue_idx;
          for (int i = 1; i < latency; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_exp[i]   <= dl_exp[i-1];
            dl_idx[i]   <= dl_idx[i-1];
          end
        end
      end

      assign cmp_valid = dl_valid[latency-1];
      assign cmp_exp   = dl_exp[latency-1];
      assign cmp_idx   = dl_idx[latency-1];
    end
  endgenerate

  assign cmp_ok   = (y == cmp_exp);
  assign cmp_last = cmp_valid && (cmp_idx == LAST_IDX);

  // Run sequencing, result counters and the mismatch pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      issue_idx  <= '0;
      pass_count <= '0;
      fail_count <= '0;
      mismatch   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            issue_idx  <= '0;
            pass_count <= '0;
            fail_count <= '0;
          end
        end
        ST_RUN: begin
          if (issue_fire) begin
            issue_idx <= issue_idx + 16'd1;
            if (issue_last) begin
              if (latency == 0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (cmp_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Compares only occur in RUN/DRAIN, so they never collide with the
      // counter clear on run entry.
      if (cmp_valid) begin
        if (cmp_ok) begin
          if (pass_count != '1) pass_count <= pass_count + 32'd1;
        end else begin
          if (fail_count != '1) fail_count <= fail_count + 32'd1;
          mismatch <= 1'b1;
        end
      end
    end
  end

  assign pass = done && (fail_count == '0);

`ifdef DSP_CHECKER_FIRST_FAIL_EN
  logic [15:0]      ff_idx_q;
  logic [width-1:0] ff_exp_q;
  logic [width-1:0] ff_act_q;

  // Capture the first mismatch of a run; fail_count is still zero on that edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ff_idx_q <= '0;
      ff_exp_q <= '0;
      ff_act_q <= '0;
    end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
      ff_idx_q <= '0;
      ff_exp_q <= '0;
      ff_act_q <= '0;
    end else if (cmp_valid && !cmp_ok && (fail_count == '0)) begin
      ff_idx_q <= cmp_idx;
      ff_exp_q <= cmp_exp;
      ff_act_q <= y;
    end
  end

  assign first_fail_index = ff_idx_q;
  assign first_fail_exp   = ff_exp_q;
  assign first_fail_act   = ff_act_q;
`else
  assign first_fail_index = '0;
  assign first_fail_exp   = '0;
  assign first_fail_act   = '0;
`endif

endmodule

// File: tb/tb_dsp_add_checker.sv
// Bench for dsp_add_checker: one instance at latency 2 fed by a two-stage
// registered DUT model, one at latency 0 fed by a combinational model.
// Expected end-of-run results are queued per run and scored when done rises.
`timescale 1ns/1ps
module tb_dsp_add_checker;

`ifdef DSP_CHECKER_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start2 = 1'b0;
  logic       start0 = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] model_in = 8'h00;
  logic [7:0] p0 = 8'h00;
  logic [7:0] p1 = 8'h00;
  logic [7:0] y2;
  logic [7:0] y0;

  logic [31:0] pc2, fc2, pc0, fc0;
  logic        mm2, busy2, done2, pass2;
  logic        mm0, busy0, done0, pass0;
  logic [15:0] ffi2, ffi0;
  logic [7:0]  ffe2, ffa2, ffe0, ffa0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_issue_cyc = 0;

  typedef struct {
    int pc; int fc; int ps; int mm; int lat; int ffi; int ffe; int ffa;
  } exp_t;
  exp_t q2[$];
  exp_t q0[$];

  dsp_add_checker #(.width(8), .latency(2), .num_tests(16)) dut (
    .clock(clock), .reset(reset), .start(start2), .in_valid(in_valid),
    .a(a), .b(b), .y(y2),
    .pass_count(pc2), .fail_count(fc2), .mismatch(mm2), .busy(busy2),
    .done(done2), .pass(pass2), .first_fail_index(ffi2),
    .first_fail_exp(ffe2), .first_fail_act(ffa2)
  );

  dsp_add_checker #(.width(8), .latency(0), .num_tests(16)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .in_valid(in_valid),
    .a(a), .b(b), .y(y0),
    .pass_count(pc0), .fail_count(fc0), .mismatch(mm0), .busy(busy0),
    .done(done0), .pass(pass0), .first_fail_index(ffi0),
    .first_fail_exp(ffe0), .first_fail_act(ffa0)
  );

  always #5 clock = ~clock;

  // Latency-2 DUT model: returns model_in two edges after it was presented.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    p0  <= model_in;
    p1  <= p0;
  end
  assign y2 = p1;
  // Latency-0 DUT model.
  assign y0 = a + b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int pc, input int fc, input int ps, input int mm,
                              input int lat, input int ffi, input int ffe, input int ffa);
    exp_t e;
    e.pc = pc; e.fc = fc; e.ps = ps; e.mm = mm;
    e.lat = lat; e.ffi = ffi; e.ffe = ffe; e.ffa = ffa;
    return e;
  endfunction

  task automatic check_zero2(input string tag);
    check({tag, "_pc2"}, pc2, 0);
    check({tag, "_fc2"}, fc2, 0);
    check({tag, "_mm2"}, 32'(mm2), 0);
    check({tag, "_busy2"}, 32'(busy2), 0);
    check({tag, "_done2"}, 32'(done2), 0);
    check({tag, "_pass2"}, 32'(pass2), 0);
    check({tag, "_ffi2"}, 32'(ffi2), 0);
    check({tag, "_ffe2"}, 32'(ffe2), 0);
    check({tag, "_ffa2"}, 32'(ffa2), 0);
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_pc0"}, pc0, 0);
    check({tag, "_fc0"}, fc0, 0);
    check({tag, "_mm0"}, 32'(mm0), 0);
    check({tag, "_busy0"}, 32'(busy0), 0);
    check({tag, "_done0"}, 32'(done0), 0);
    check({tag, "_pass0"}, 32'(pass0), 0);
  endtask

  // Monitor for the latency-2 instance.
  initial begin
    int   mcount;
    logic done_q;
    exp_t e;
    mcount = 0;
    done_q = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mcount = 0;
        done_q = 1'b0;
      end else begin
        if (mm2) mcount++;
        if (done2 && !done_q) begin
          if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done2: got done with empty queue, required none");
          end else begin
            e = q2.pop_front();
            check("run2_pass_count", pc2, e.pc);
            check("run2_fail_count", fc2, e.fc);
            check("run2_pass", 32'(pass2), e.ps);
            check("run2_mismatch_pulses", mcount, e.mm);
            check("run2_done_latency", cyc - last_issue_cyc, e.lat);
            check("run2_ff_index", 32'(ffi2), e.ffi);
            check("run2_ff_exp", 32'(ffe2), e.ffe);
            check("run2_ff_act", 32'(ffa2), e.ffa);
          end
          mcount = 0;
        end
        done_q = done2;
      end
    end
  end

  // Monitor for the latency-0 instance.
  initial begin
    int   mcount;
    logic done_q;
    exp_t e;
    mcount = 0;
    done_q = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mcount = 0;
        done_q = 1'b0;
      end else begin
        if (mm0) mcount++;
        if (done0 && !done_q) begin
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done0: got done with empty queue, required none");
          end else begin
            e = q0.pop_front();
            check("run0_pass_count", pc0, e.pc);
            check("run0_fail_count", fc0, e.fc);
            check("run0_pass", 32'(pass0), e.ps);
            check("run0_mismatch_pulses", mcount, e.mm);
            check("run0_done_latency", cyc - last_issue_cyc, e.lat);
            check("run0_ff_index", 32'(ffi0), e.ffi);
          end
          mcount = 0;
        end
        done_q = done0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input bit which0);
    tick();
    if (which0) start0 = 1'b1; else start2 = 1'b1;
    tick();
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  // Issues 16 vectors; model output is good_y except at inject_idx.
  task automatic issue16(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] good_y,
                         input int inject_idx, input logic [7:0] inject_y, input bit bubbles);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      a = va;
      b = vb;
      model_in = (i == inject_idx) ? inject_y : good_y;
      tick();
      if (bubbles && i < 15) begin
        in_valid = 1'b0;
        a = 8'h33;
        b = 8'h44;
        model_in = 8'hAA;
        tick();
      end
    end
    last_issue_cyc = cyc;
  endtask

  task automatic wait_done(input bit which0, input bit drain_valid);
    int n;
    n = 0;
    in_valid = drain_valid;
    a = 8'h01;
    b = 8'h01;
    model_in = 8'hAA;
    while (((which0 ? done0 : done2) !== 1'b1) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(which0 ? "done0_within_bound" : "done2_within_bound", 32'(n < 40), 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    // Reset held three cycles with start asserted.
    reset = 1'b1;
    start2 = 1'b1;
    start0 = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check_zero2("reset");
      check_zero0("reset");
    end
    tick();
    reset = 1'b0;
    start2 = 1'b0;
    start0 = 1'b0;

    // in_valid toggling in IDLE must not issue anything.
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      a = 8'h12;
      b = 8'h34;
      model_in = 8'h99;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check_zero2("idle");
    check_zero0("idle");

    // Clean run: FF+10 wraps to 0F.
    q2.push_back(mk(16, 0, 1, 0, 2, 0, 0, 0));
    do_start(1'b0);
    issue16(8'hFF, 8'h10, 8'h0F, -1, 8'h00, 1'b0);
    wait_done(1'b0, 1'b0);

    // Injected error at vector 5; in_valid held high through DRAIN/DONE.
    q2.push_back(mk(15, 1, 0, 1, 2, FF_EN ? 5 : 0, FF_EN ? 32'h0F : 0, FF_EN ? 32'h10 : 0));
    do_start(1'b0);
    issue16(8'hFF, 8'h10, 8'h0F, 5, 8'h10, 1'b0);
    wait_done(1'b0, 1'b1);

    // Bubbles: AA on the bubble slots is never compared.
    q2.push_back(mk(16, 0, 1, 0, 2, 0, 0, 0));
    do_start(1'b0);
    issue16(8'hFF, 8'h10, 8'h0F, -1, 8'h00, 1'b1);
    wait_done(1'b0, 1'b0);

    // Zero latency: 80+80 wraps to 00, done on the last issue edge.
    q0.push_back(mk(16, 0, 1, 0, 0, 0, 0, 0));
    do_start(1'b1);
    issue16(8'h80, 8'h80, 8'h00, -1, 8'h00, 1'b0);
    wait_done(1'b1, 1'b0);

    // Reset in DRAIN with two entries in flight.
    do_start(1'b0);
    issue16(8'hFF, 8'h10, 8'h0F, -1, 8'h00, 1'b0);
    check("drain_busy_before_reset", 32'(busy2), 1);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    check_zero2("mid_drain_reset");
    tick();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("post_reset_pc2", pc2, 0);
      check("post_reset_fc2", fc2, 0);
      check("post_reset_busy2", 32'(busy2), 0);
      check("post_reset_done2", 32'(done2), 0);
    end
    q2.push_back(mk(16, 0, 1, 0, 2, 0, 0, 0));
    do_start(1'b0);
    issue16(8'hFF, 8'h10, 8'h0F, -1, 8'h00, 1'b0);
    wait_done(1'b0, 1'b0);

    repeat (4) tick();
    check("q2_drained", q2.size(), 0);
    check("q0_drained", q0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
